// File: rtl/sts_peak_detect.sv
// Sliding-window STS correlator with periodic-peak tracking that declares sync after PEAK_NUM peaks.
// Optional feature: define PEAK_TOL_EN so TRACK accepts a peak at PEAK_GAP-1, PEAK_GAP or PEAK_GAP+1.
module sts_peak_detect #(
  parameter int WIN_LEN  = 16,
  parameter int PEAK_NUM = 10,
  parameter int PEAK_GAP = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               inEn,
  input  logic signed [16:0] in_Real,
  input  logic signed [16:0] in_Imag,
  input  logic        [21:0] threshold,
  input  logic               sync_Clr,
  output logic signed [20:0] corr_Real,
  output logic signed [20:0] corr_Imag,
  output logic        [21:0] corr_Mag,
  output logic               OutputEnable,
  output logic               peak_Flag,
  output logic        [4:0]  peak_Count,
  output logic               sync_Done
);

  localparam logic [1:0] FILL   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] TRACK  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam int FW = $clog2(WIN_LEN) + 1;
  localparam int GW = $clog2(PEAK_GAP + 2) + 1;
  localparam logic [FW-1:0] FILL_LAST = FW'(WIN_LEN - 1);
  localparam logic [FW-1:0] FILL_ONE  = {{(FW-1){1'b0}}, 1'b1};
  localparam logic [GW-1:0] GAP_ONE   = {{(GW-1){1'b0}}, 1'b1};
  localparam logic [4:0]    PEAK_TGT  = 5'(PEAK_NUM);
`ifdef PEAK_TOL_EN
  localparam logic [GW-1:0] GAP_LO = GW'(PEAK_GAP - 1);
  localparam logic [GW-1:0] GAP_HI = GW'(PEAK_GAP + 1);
`else
  localparam logic [GW-1:0] GAP_NOM = GW'(PEAK_GAP);
`endif

  function automatic logic signed [20:0] sext17(input logic signed [16:0] v);
    return {{4{v[16]}}, v};
  endfunction

  // -(-2^20) wraps to 2^20, which is still correct as an unsigned 21-bit magnitude
  function automatic logic [20:0] abs21(input logic signed [20:0] v);
    logic [20:0] r;
    if (v[20]) begin
      r = $unsigned(-v);
    end else begin
      r = $unsigned(v);
    end
    return r;
  endfunction

  logic signed [16:0] dl_re_r [WIN_LEN];
  logic signed [16:0] dl_im_r [WIN_LEN];
  logic signed [20:0] sum_re_r, sum_im_r;
  logic               vld1_r;
  logic        [1:0]  state_r, state_n;
  logic      [FW-1:0] fill_r, fill_n;
  logic      [GW-1:0] gap_r, gap_n, gap_inc_s;
  logic        [4:0]  cnt_n;
  logic               flag_n, done_n, hit_s;
  logic        [21:0] mag_s;

  assign mag_s     = {1'b0, abs21(sum_re_r)} + {1'b0, abs21(sum_im_r)};
  assign hit_s     = (mag_s > threshold);
  assign gap_inc_s = gap_r + GAP_ONE;

  // Stage 1: delay line and running window sums, advanced only by accepted samples
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < WIN_LEN; i++) begin
        dl_re_r[i] <= 17'sd0;
        dl_im_r[i] <= 17'sd0;
      end
      sum_re_r <= 21'sd0;
      sum_im_r <= 21'sd0;
      vld1_r   <= 1'b0;
    end else if (sync_Clr) begin
      for (int i = 0; i < WIN_LEN; i++) begin
        dl_re_r[i] <= 17'sd0;
        dl_im_r[i] <= 17'sd0;
      end
      sum_re_r <= 21'sd0;
      sum_im_r <= 21'sd0;
      vld1_r   <= 1'b0;
    end else begin
      vld1_r <= inEn;
      if (inEn) begin
        dl_re_r[0] <= in_Real;
        dl_im_r[0] <= in_Imag;
        for (int i = 1; i < WIN_LEN; i++) begin
          dl_re_r[i] <= dl_re_r[i-1];
          dl_im_r[i] <= dl_im_r[i-1];
        end
        // The line is flushed to zero, so the oldest tap reads 0 until it has filled
        sum_re_r <= sum_re_r + sext17(in_Real) - sext17(dl_re_r[WIN_LEN-1]);
        sum_im_r <= sum_im_r + sext17(in_Imag) - sext17(dl_im_r[WIN_LEN-1]);
      end
    end
  end

  // Peak-tracking next state, evaluated only on cycles that produce an output
  always_comb begin
    state_n = state_r;
    fill_n  = fill_r;
    gap_n   = gap_r;
    cnt_n   = peak_Count;
    flag_n  = 1'b0;
    done_n  = 1'b0;
    if (vld1_r) begin
      case (state_r)
        FILL: begin
          if (fill_r == FILL_LAST) begin
            state_n = SEARCH;
            fill_n  = '0;
          end else begin
            fill_n = fill_r + FILL_ONE;
          end
        end
        SEARCH: begin
          if (hit_s) begin
            flag_n  = 1'b1;
            cnt_n   = 5'd1;
            gap_n   = '0;
            state_n = TRACK;
          end else begin
            state_n = SEARCH;
          end
        end
        TRACK: begin
          gap_n = gap_inc_s;
`ifdef PEAK_TOL_EN
          if (hit_s && (gap_inc_s >= GAP_LO) && (gap_inc_s <= GAP_HI)) begin
            flag_n = 1'b1;
            cnt_n  = peak_Count + 5'd1;
            gap_n  = '0;
          end else if (gap_inc_s >= GAP_HI) begin
            cnt_n   = 5'd0;
            gap_n   = '0;
            state_n = SEARCH;
          end else begin
            state_n = TRACK;
          end
`else
          if (gap_inc_s == GAP_NOM) begin
            if (hit_s) begin
              flag_n = 1'b1;
              cnt_n  = peak_Count + 5'd1;
              gap_n  = '0;
            end else begin
              cnt_n   = 5'd0;
              gap_n   = '0;
              state_n = SEARCH;
            end
          end else begin
            state_n = TRACK;
          end
`endif
        end
        DONE: begin
          state_n = DONE;
        end
        default: begin
          state_n = FILL;
        end
      endcase
      if (flag_n && (cnt_n == PEAK_TGT)) begin
        done_n  = 1'b1;
        state_n = DONE;
      end else begin
        done_n = 1'b0;
      end
    end else begin
      state_n = state_r;
    end
  end

  // Stage 2: registered outputs, zeroed whenever no output is valid
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r      <= FILL;
      fill_r       <= '0;
      gap_r        <= '0;
      peak_Count   <= 5'd0;
      peak_Flag    <= 1'b0;
      sync_Done    <= 1'b0;
      OutputEnable <= 1'b0;
      corr_Real    <= 21'sd0;
      corr_Imag    <= 21'sd0;
      corr_Mag     <= 22'd0;
    end else if (sync_Clr) begin
      state_r      <= FILL;
      fill_r       <= '0;
      gap_r        <= '0;
      peak_Count   <= 5'd0;
      peak_Flag    <= 1'b0;
      sync_Done    <= 1'b0;
      OutputEnable <= 1'b0;
      corr_Real    <= 21'sd0;
      corr_Imag    <= 21'sd0;
      corr_Mag     <= 22'd0;
    end else begin
      state_r      <= state_n;
      fill_r       <= fill_n;
      gap_r        <= gap_n;
      peak_Count   <= cnt_n;
      peak_Flag    <= flag_n;
      sync_Done    <= done_n;
      OutputEnable <= vld1_r;
      if (vld1_r) begin
        corr_Real <= sum_re_r;
        corr_Imag <= sum_im_r;
        corr_Mag  <= mag_s;
      end else begin
        corr_Real <= 21'sd0;
        corr_Imag <= 21'sd0;
        corr_Mag  <= 22'd0;
      end
    end
  end

endmodule

// File: tb/tb_sts_peak_detect.sv
// Self-checking bench for sts_peak_detect: vector table plus scoreboard driven by an output-indexed model.
`timescale 1ns/1ps
module tb_sts_peak_detect;

  localparam int WIN_LEN  = 16;
  localparam int PEAK_NUM = 10;
  localparam int PEAK_GAP = 16;

  logic               Clk = 1'b0;
  logic               Rst;
  logic               inEn;
  logic signed [16:0] in_Real, in_Imag;
  logic        [21:0] threshold;
  logic               sync_Clr;
  logic signed [20:0] corr_Real, corr_Imag;
  logic        [21:0] corr_Mag;
  logic               OutputEnable, peak_Flag, sync_Done;
  logic        [4:0]  peak_Count;

  always #5 Clk = ~Clk;

  sts_peak_detect #(.WIN_LEN(WIN_LEN), .PEAK_NUM(PEAK_NUM), .PEAK_GAP(PEAK_GAP)) dut (
    .Clk(Clk), .Rst(Rst), .inEn(inEn), .in_Real(in_Real), .in_Imag(in_Imag),
    .threshold(threshold), .sync_Clr(sync_Clr), .corr_Real(corr_Real), .corr_Imag(corr_Imag),
    .corr_Mag(corr_Mag), .OutputEnable(OutputEnable), .peak_Flag(peak_Flag),
    .peak_Count(peak_Count), .sync_Done(sync_Done)
  );

  typedef struct {
    longint re, im, mag;
    int     flag, cnt, done;
  } exp_t;

  typedef struct {
    int     in_re, in_im;
    longint exp_re, exp_im, exp_mag;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[20];
  int   hist_re[$], hist_im[$];
  int   n_checks = 0, n_errors = 0, done_seen = 0, last_cnt = 0;
  int   m_out, m_state, m_cnt, m_last, c_prev_re, c_prev_im, spike_sign;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist_re.delete();
    hist_im.delete();
    m_out = 0; m_state = 0; m_cnt = 0; m_last = 0;
    c_prev_re = 0; c_prev_im = 0; spike_sign = 1;
  endtask

  // Window sum by direct summation; peak decisions by output index distance
  task automatic model_push(input int re, input int im);
    exp_t   e;
    longint sre, sim;
    int     d, lo, hi;
    hist_re.push_back(re);
    hist_im.push_back(im);
    sre = 0; sim = 0;
    for (int j = 0; j < WIN_LEN && j < hist_re.size(); j++) begin
      sre += hist_re[hist_re.size()-1-j];
      sim += hist_im[hist_im.size()-1-j];
    end
    e.re = sre; e.im = sim;
    e.mag = (sre < 0 ? -sre : sre) + (sim < 0 ? -sim : sim);
    e.flag = 0; e.done = 0;
`ifdef PEAK_TOL_EN
    lo = PEAK_GAP - 1; hi = PEAK_GAP + 1;
`else
    lo = PEAK_GAP; hi = PEAK_GAP;
`endif
    m_out++;
    case (m_state)
      0: if (m_out >= WIN_LEN) m_state = 1;
      1: if (e.mag > longint'(threshold)) begin
           e.flag = 1; m_cnt = 1; m_last = m_out; m_state = 2;
         end
      2: begin
           d = m_out - m_last;
           if (d >= lo && d <= hi && e.mag > longint'(threshold)) begin
             e.flag = 1; m_cnt++; m_last = m_out;
           end else if (d >= hi) begin
             m_cnt = 0; m_state = 1;
           end
         end
      default: ;
    endcase
    if (e.flag == 1 && m_cnt == PEAK_NUM) begin
      e.done = 1; m_state = 3;
    end
    e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    if (OutputEnable) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output_enable", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("corr_Real", corr_Real, e.re);
        chk("corr_Imag", corr_Imag, e.im);
        chk("corr_Mag", corr_Mag, e.mag);
        chk("peak_Flag", peak_Flag, e.flag);
        chk("peak_Count", peak_Count, e.cnt);
        chk("sync_Done", sync_Done, e.done);
        last_cnt = e.cnt;
        if (sync_Done) done_seen++;
      end
    end else begin
      chk("idle_corr_Real", corr_Real, 0);
      chk("idle_corr_Imag", corr_Imag, 0);
      chk("idle_corr_Mag", corr_Mag, 0);
      chk("idle_peak_Flag", peak_Flag, 0);
      chk("idle_sync_Done", sync_Done, 0);
      chk("idle_peak_Count", peak_Count, last_cnt);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    monitor();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input int re, input int im);
    inEn = 1'b1;
    in_Real = 17'(re);
    in_Imag = 17'(im);
    model_push(re, im);
    tick();
    inEn = 1'b0;
    in_Real = 17'($urandom);
    in_Imag = 17'($urandom);
  endtask

  // Choose the sample that makes the window sum equal the requested target
  task automatic drive_target(input int cre, input int cim, input int toggle);
    int xre, xim, n;
    n = hist_re.size();
    xre = cre - c_prev_re + (n >= WIN_LEN ? hist_re[n-WIN_LEN] : 0);
    xim = cim - c_prev_im + (n >= WIN_LEN ? hist_im[n-WIN_LEN] : 0);
    c_prev_re = cre;
    c_prev_im = cim;
    send(xre, xim);
    if (toggle != 0) tick();
  endtask

  // Alternating-sign spikes keep the generated samples inside 17 bits
  task automatic train(input int lead, input int npk, input int gap,
                       input int miss_idx, input int miss_amp, input int toggle);
    int amp;
    for (int z = 0; z < lead; z++) drive_target(0, 0, toggle);
    for (int k = 0; k < npk; k++) begin
      amp = (k == miss_idx) ? miss_amp : 30000;
      drive_target(spike_sign * (amp - amp / 3), -spike_sign * (amp / 3), toggle);
      spike_sign = -spike_sign;
      for (int z = 1; z < gap; z++) drive_target(0, 0, toggle);
    end
  endtask

  task automatic clear_run(input int re, input int im);
    sync_Clr = 1'b1;
    inEn = 1'b1;
    in_Real = 17'(re);
    in_Imag = 17'(im);
    tick();
    exp_q.delete();
    model_reset();
    last_cnt = 0;
    sync_Clr = 1'b0;
    inEn = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; inEn = 1'b0; sync_Clr = 1'b0;
    in_Real = 17'sd0; in_Imag = 17'sd0; threshold = 22'h3FFFFF;
    model_reset();
    repeat (2) tick();
    chk("reset_OutputEnable", OutputEnable, 0);
    chk("reset_peak_Count", peak_Count, 0);
    chk("reset_corr_Mag", corr_Mag, 0);
    Rst = 1'b0;
    tick();

    // Window fill with a constant sample, then decay as zeros push it out
    for (int i = 0; i < 20; i++) begin
      vecs[i].in_re  = (i < 16) ? 1000 : 0;
      vecs[i].in_im  = (i < 16) ? -500 : 0;
      vecs[i].exp_re = (i < 16) ? 1000 * (i + 1) : 1000 * (31 - i);
      vecs[i].exp_im = (i < 16) ? -500 * (i + 1) : -500 * (31 - i);
      vecs[i].exp_mag = (i < 16) ? 1500 * (i + 1) : 1500 * (31 - i);
    end
    for (int i = 0; i <= 20; i++) begin
      if (i < 20) send(vecs[i].in_re, vecs[i].in_im);
      else tick();
      if (i == 0) begin
        chk("latency_not_early", OutputEnable, 0);
      end else begin
        chk("tbl_oe", OutputEnable, 1);
        chk("tbl_re", corr_Real, vecs[i-1].exp_re);
        chk("tbl_im", corr_Imag, vecs[i-1].exp_im);
        chk("tbl_mag", corr_Mag, vecs[i-1].exp_mag);
      end
    end

    // Ideal STS train, then extra peaks while in DONE
    threshold = 22'd20000;
    clear_run(0, 0);
    done_seen = 0;
    train(20, 10, 16, -1, 0, 0);
    train(0, 2, 16, -1, 0, 0);
    repeat (3) tick();
    chk("sts_sync_pulses", done_seen, 1);
    chk("sts_final_count", peak_Count, 10);

    // 4th peak exactly at threshold is not a peak; search re-acquires afterwards
    clear_run(0, 0);
    done_seen = 0;
    train(20, 8, 16, 3, 20000, 0);
    repeat (3) tick();
    chk("miss_sync_pulses", done_seen, 0);
    chk("miss_final_count", peak_Count, 4);

    // Same train with inEn gaps between every sample
    clear_run(0, 0);
    done_seen = 0;
    train(20, 10, 16, -1, 0, 1);
    repeat (3) tick();
    chk("gap_sync_pulses", done_seen, 1);
    chk("gap_final_count", peak_Count, 10);

    // Clear with a sample mid-TRACK: that sample and everything earlier vanish
    clear_run(0, 0);
    train(20, 5, 16, -1, 0, 0);
    drive_target(0, 0, 0);
    drive_target(0, 0, 0);
    clear_run(1234, -4321);
    send(300, -200);
    tick();
    chk("clr_first_oe", OutputEnable, 1);
    chk("clr_first_re", corr_Real, 300);
    chk("clr_first_im", corr_Imag, -200);
    chk("clr_first_count", peak_Count, 0);
    send(50, 70);
    repeat (3) tick();

    // Peaks spaced by PEAK_GAP+1
    clear_run(0, 0);
    done_seen = 0;
    train(20, 11, 17, -1, 0, 0);
    repeat (3) tick();
`ifdef PEAK_TOL_EN
    chk("tol_sync_pulses", done_seen, 1);
`else
    chk("notol_sync_pulses", done_seen, 0);
`endif

    // Asynchronous reset mid-train, then a fresh fill
    clear_run(0, 0);
    train(20, 3, 16, -1, 0, 0);
    Rst = 1'b1;
    exp_q.delete();
    model_reset();
    last_cnt = 0;
    #1;
    chk("rst_mid_oe", OutputEnable, 0);
    chk("rst_mid_count", peak_Count, 0);
    chk("rst_mid_re", corr_Real, 0);
    tick();
    Rst = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) send(1000, -500);
    tick();
    chk("refill_re", corr_Real, 16000);
    chk("refill_im", corr_Imag, -8000);
    chk("refill_mag", corr_Mag, 24000);
    repeat (4) tick();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
